// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared types and defaults for the vector-add memory slave
//
// Purpose: FSM state type, default bus/array geometry and statistics counter
// widths used by vec_mem_slave_if, vec_mem_array and vec_mem_slave.
// Ports: none (package).
package vec_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int DEF_WA         = 32;
  localparam int DEF_WD         = 32;
  localparam int DEF_ASHIFT     = 5;
  localparam int DEF_DEPTH_LOG2 = 12;
  localparam int DEF_LATENCY    = 3;

  localparam int RDCNT_W  = 16;
  localparam int WRCNT_W  = 16;
  localparam int ERRCNT_W = 8;
  // Wide enough for the largest legal latency (15).
  localparam int LATCNT_W = 4;

endpackage

// File: rtl/vec_mem_slave_if.sv
// rtl/vec_mem_slave_if.sv - MEM* request/response bus between vector-add master and memory slave
//
// Purpose: groups the single-outstanding memory request bus.
// Signals:
//   MEMA    [WA]  request byte address        (master -> slave)
//   MEMRE         read request                (master -> slave)
//   MEMWE         write request               (master -> slave)
//   MEMD    [WD]  write data                  (master -> slave)
//   MEMQ    [WD]  read data, valid with DONE  (slave -> master)
//   MEMBUSY       request in progress         (slave -> master)
//   MEMDONE       one-cycle completion pulse  (slave -> master)
interface vec_mem_slave_if
  import vec_mem_pkg::*;
#(
  parameter int WA = DEF_WA,
  parameter int WD = DEF_WD
);

  logic [WA-1:0] MEMA;
  logic          MEMRE;
  logic          MEMWE;
  logic [WD-1:0] MEMD;
  logic [WD-1:0] MEMQ;
  logic          MEMBUSY;
  logic          MEMDONE;

  modport master (
    output MEMA, MEMRE, MEMWE, MEMD,
    input  MEMQ, MEMBUSY, MEMDONE
  );

  modport slave (
    input  MEMA, MEMRE, MEMWE, MEMD,
    output MEMQ, MEMBUSY, MEMDONE
  );

endinterface

// File: rtl/vec_mem_array.sv
// rtl/vec_mem_array.sv - synchronous 1R1W word array with registered read port
//
// Purpose: backing store for the memory slave. Contents are never reset;
// only the read data register is cleared by reset.
// Ports:
//   CLK             clock, rising edge
//   RSTX            async active-low reset (read register only)
//   we/waddr/wdata  write port, commits on the clock edge
//   re/raddr        read enable/index, sampled on the clock edge
//   rdata   [WD]    registered read data, holds while re is low
module vec_mem_array #(
  parameter int WD = 32,
  parameter int AW = 12
) (
  input  logic          CLK,
  input  logic          RSTX,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [WD-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [WD-1:0] rdata
);

  logic [WD-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/vec_mem_slave.sv
// rtl/vec_mem_slave.sv - single-outstanding memory slave with fixed access latency
//
// Purpose: accepts one read/write at a time on the MEM* bus, holds MEMBUSY
// for LATENCY cycles, pulses MEMDONE with read data on MEMQ, and counts
// completed reads, writes and RE/WE collisions.
// Ports:
//   CLK            clock, rising edge
//   RSTX           async active-low reset
//   bus            vec_mem_slave_if.slave (MEMA/MEMRE/MEMWE/MEMD in, MEMQ/MEMBUSY/MEMDONE out)
//   RDCNT  [16]    completed reads, saturating
//   WRCNT  [16]    completed writes, saturating
//   ERRCNT [8]     RE+WE collisions, saturating
module vec_mem_slave
  import vec_mem_pkg::*;
#(
  parameter int WA         = DEF_WA,
  parameter int WD         = DEF_WD,
  parameter int ASHIFT     = DEF_ASHIFT,
  parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                CLK,
  input  logic                RSTX,
  vec_mem_slave_if.slave      bus,
  output logic [RDCNT_W-1:0]  RDCNT,
  output logic [WRCNT_W-1:0]  WRCNT,
  output logic [ERRCNT_W-1:0] ERRCNT
);

  localparam logic [LATCNT_W-1:0] LAT_LAST = LATCNT_W'(LATENCY - 1);

  state_e                  state_q, state_n;
  logic [LATCNT_W-1:0]     lat_q;
  logic [DEPTH_LOG2-1:0]   idx_in, idx_q;
  logic                    wr_q, err_q;
  logic                    busy_q, done_q;
  logic                    accept;
  logic                    rd_now;
  logic                    arr_re;
  logic [DEPTH_LOG2-1:0]   arr_raddr;
  logic [WD-1:0]           arr_rdata;

  // Address bits outside the word index are ignored (sub-word offset and wrap).
  assign idx_in = bus.MEMA[ASHIFT +: DEPTH_LOG2];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.MEMA[ASHIFT-1:0], bus.MEMA[WA-1:ASHIFT+DEPTH_LOG2]};

  assign accept = (state_q == ST_IDLE) && (bus.MEMRE || bus.MEMWE);

  always_comb begin
    state_n = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_n = (LATENCY == 1) ? ST_RESP : ST_WAIT;
      ST_WAIT: if (lat_q == LAT_LAST) state_n = ST_RESP;
      ST_RESP: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  // With LATENCY=1 the read happens on the accept edge itself, before the
  // operation is latched, so take it straight from the bus in that case.
  assign rd_now    = (state_q == ST_IDLE) ? !bus.MEMWE : !wr_q;
  assign arr_re    = (state_n == ST_RESP) && (state_q != ST_RESP) && rd_now;
  assign arr_raddr = (state_q == ST_IDLE) ? idx_in : idx_q;

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      // Busy/done are registered from the next state so outputs carry no
      // combinational path from the request inputs.
      busy_q  <= (state_n != ST_IDLE);
      done_q  <= (state_n == ST_RESP);
      if (accept) begin
        idx_q <= idx_in;
        wr_q  <= bus.MEMWE;
        err_q <= bus.MEMWE && bus.MEMRE;
        lat_q <= LATCNT_W'(1);
      end else if (state_q == ST_WAIT) begin
        lat_q <= lat_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      RDCNT  <= '0;
      WRCNT  <= '0;
      ERRCNT <= '0;
    end else if (state_q == ST_RESP) begin
      if (wr_q) begin
        if (!(&WRCNT)) WRCNT <= WRCNT + 1'b1;
      end else begin
        if (!(&RDCNT)) RDCNT <= RDCNT + 1'b1;
      end
      if (err_q && !(&ERRCNT)) ERRCNT <= ERRCNT + 1'b1;
    end
  end

  // Writes (including collisions) commit on the accept edge.
  vec_mem_array #(
    .WD (WD),
    .AW (DEPTH_LOG2)
  ) u_array (
    .CLK   (CLK),
    .RSTX  (RSTX),
    .we    (accept && bus.MEMWE),
    .waddr (idx_in),
    .wdata (bus.MEMD),
    .re    (arr_re),
    .raddr (arr_raddr),
    .rdata (arr_rdata)
  );

  assign bus.MEMQ    = arr_rdata;
  assign bus.MEMBUSY = busy_q;
  assign bus.MEMDONE = done_q;

endmodule

// File: tb/tb_vec_mem_slave.sv
// tb/tb_vec_mem_slave.sv - self-checking bench for vec_mem_slave (LATENCY=3 and LATENCY=1 instances)
module tb_vec_mem_slave;

  logic clk = 1'b0;
  logic rstx3, rstx1;
  always #5 clk = ~clk;

  vec_mem_slave_if #(.WA(32), .WD(32)) bus3 ();
  vec_mem_slave_if #(.WA(32), .WD(32)) bus1 ();

  logic [15:0] rdcnt3, wrcnt3, rdcnt1, wrcnt1;
  logic [7:0]  errcnt3, errcnt1;

  vec_mem_slave #(.LATENCY(3)) dut3 (
    .CLK(clk), .RSTX(rstx3), .bus(bus3.slave),
    .RDCNT(rdcnt3), .WRCNT(wrcnt3), .ERRCNT(errcnt3)
  );

  vec_mem_slave #(.LATENCY(1)) dut1 (
    .CLK(clk), .RSTX(rstx1), .bus(bus1.slave),
    .RDCNT(rdcnt1), .WRCNT(wrcnt1), .ERRCNT(errcnt1)
  );

  typedef struct {
    logic [31:0] addr;
    bit          re;
    bit          we;
    logic [31:0] data;
    logic [31:0] exp_q;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [31:0] a, input bit re, input bit we, input logic [31:0] d);
    if (sel) begin
      bus1.MEMA = a; bus1.MEMRE = re; bus1.MEMWE = we; bus1.MEMD = d;
    end else begin
      bus3.MEMA = a; bus3.MEMRE = re; bus3.MEMWE = we; bus3.MEMD = d;
    end
  endtask

  function automatic logic f_done(input bit sel);
    return sel ? bus1.MEMDONE : bus3.MEMDONE;
  endfunction
  function automatic logic f_busy(input bit sel);
    return sel ? bus1.MEMBUSY : bus3.MEMBUSY;
  endfunction
  function automatic logic [31:0] f_q(input bit sel);
    return sel ? bus1.MEMQ : bus3.MEMQ;
  endfunction

  // One complete access: drive for one accept edge, then wait for DONE,
  // checking latency, read data (scoreboard) or unchanged MEMQ (writes).
  task automatic access(input bit sel, input logic [31:0] a, input bit re, input bit we,
                        input logic [31:0] d, input logic [31:0] exp_q, output logic [31:0] q_out);
    int lat;
    bit got;
    logic [31:0] q_before;
    logic [31:0] e;
    lat = sel ? 1 : 3;
    q_out = 'x;
    @(negedge clk);
    q_before = f_q(sel);
    drive(sel, a, re, we, d);
    if (re && !we) sb_q.push_back(exp_q);
    @(posedge clk);
    #1 drive(sel, a, 1'b0, 1'b0, d);
    got = 0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(negedge clk);
      if (f_done(sel)) begin
        got = 1;
        check("done_latency", 32'(c), 32'(lat));
        check("busy_in_done_cycle", 32'(f_busy(sel)), 32'd1);
        q_out = f_q(sel);
        if (re && !we) begin
          if (sb_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL scoreboard_empty: got DONE for read with no expected entry");
          end else begin
            e = sb_q.pop_front();
            check("read_data", f_q(sel), e);
          end
        end else begin
          check("memq_unchanged_by_write", f_q(sel), q_before);
        end
      end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: got no DONE within 20 cycles expected DONE after %0d", lat);
    end
    @(negedge clk);
    check("busy_after_done", 32'(f_busy(sel)), 32'd0);
    check("done_one_cycle", 32'(f_done(sel)), 32'd0);
  endtask

  vec_t tbl[8];
  logic [31:0] q, qa, qb;
  int exp_rd, exp_wr, exp_err, ndone;
  bit got;

  initial begin
    rstx3 = 1'b0;
    rstx1 = 1'b0;
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0);

    tbl[0] = '{32'h0000_8000, 1'b0, 1'b1, 32'h0000_0005, 32'h0};
    tbl[1] = '{32'h0000_8000, 1'b1, 1'b0, 32'h0,         32'h0000_0005};
    tbl[2] = '{32'h0000_0040, 1'b1, 1'b1, 32'h0000_00A5, 32'h0};
    tbl[3] = '{32'h0000_0040, 1'b1, 1'b0, 32'h0,         32'h0000_00A5};
    tbl[4] = '{32'h0000_005F, 1'b1, 1'b0, 32'h0,         32'h0000_00A5};
    tbl[5] = '{32'h0002_8000, 1'b1, 1'b0, 32'h0,         32'h0000_0005};
    tbl[6] = '{32'hFFFF_FFE0, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'h0};
    tbl[7] = '{32'h0001_FFE0, 1'b1, 1'b0, 32'h0,         32'hDEAD_BEEF};

    // Reset held with RE high: everything quiet.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(bus3.MEMBUSY), 32'd0);
    check("rst_done", 32'(bus3.MEMDONE), 32'd0);
    check("rst_memq", bus3.MEMQ, 32'd0);
    check("rst_rdcnt", 32'(rdcnt3), 32'd0);
    check("rst_wrcnt", 32'(wrcnt3), 32'd0);
    check("rst_errcnt", 32'(errcnt3), 32'd0);
    rstx3 = 1'b1;
    rstx1 = 1'b1;
    @(posedge clk);
    #1 drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("accept_after_reset_release", 32'(bus3.MEMBUSY), 32'd1);
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (!bus3.MEMBUSY) got = 1;
    end
    check("first_access_completes", 32'(got), 32'd1);
    // Clear the counters from that read (array contents are kept).
    rstx3 = 1'b0;
    @(negedge clk);
    rstx3 = 1'b1;

    // Table-driven vectors on the LATENCY=3 instance.
    exp_rd = 0; exp_wr = 0; exp_err = 0;
    for (int i = 0; i < 8; i++) begin
      access(1'b0, tbl[i].addr, tbl[i].re, tbl[i].we, tbl[i].data, tbl[i].exp_q, q);
      if (tbl[i].we) exp_wr++; else exp_rd++;
      if (tbl[i].we && tbl[i].re) exp_err++;
    end
    check("tbl_rdcnt", 32'(rdcnt3), 32'(exp_rd));
    check("tbl_wrcnt", 32'(wrcnt3), 32'(exp_wr));
    check("tbl_errcnt", 32'(errcnt3), 32'(exp_err));

    // Held request: RE stays high through the first BUSY cycle.
    @(negedge clk);
    drive(1'b0, 32'h0000_8000, 1'b1, 1'b0, 32'h0);
    sb_q.push_back(32'h0000_0005);
    @(posedge clk);
    @(posedge clk);
    #1 drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    ndone = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus3.MEMDONE) begin
        ndone++;
        if (sb_q.size() != 0) begin
          qa = sb_q.pop_front();
          check("held_read_data", bus3.MEMQ, qa);
        end
      end
    end
    check("held_done_count", 32'(ndone), 32'd1);
    check("held_rdcnt", 32'(rdcnt3), 32'(exp_rd + 1));

    // LATENCY=1 instance: write index 1, read it back through a wrapped address.
    access(1'b1, 32'h0000_0020, 1'b0, 1'b1, 32'h0000_0077, 32'h0, q);
    access(1'b1, (32'd4096 << 5) + 32'h20, 1'b1, 1'b0, 32'h0, 32'h0000_0077, q);
    check("lat1_rdcnt", 32'(rdcnt1), 32'd1);
    check("lat1_wrcnt", 32'(wrcnt1), 32'd1);

    // Integration: preload regions 0/1, clear counters, run vector add.
    for (int i = 0; i < 1024; i++) begin
      access(1'b0, 32'(i) << 5, 1'b0, 1'b1, 32'(i), 32'h0, q);
      access(1'b0, 32'h8000 + (32'(i) << 5), 1'b0, 1'b1, 32'(2 * i), 32'h0, q);
    end
    @(negedge clk);
    rstx3 = 1'b0;
    @(negedge clk);
    rstx3 = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      access(1'b0, 32'(i) << 5, 1'b1, 1'b0, 32'h0, 32'(i), qa);
      access(1'b0, 32'h8000 + (32'(i) << 5), 1'b1, 1'b0, 32'h0, 32'(2 * i), qb);
      access(1'b0, 32'h10000 + (32'(i) << 5), 1'b0, 1'b1, qa + qb, 32'h0, q);
    end
    check("vadd_rdcnt", 32'(rdcnt3), 32'd2048);
    check("vadd_wrcnt", 32'(wrcnt3), 32'd1024);
    check("vadd_errcnt", 32'(errcnt3), 32'd0);
    for (int i = 0; i < 1024; i++) begin
      access(1'b0, 32'h10000 + (32'(i) << 5), 1'b1, 1'b0, 32'h0, 32'(3 * i), q);
    end

    // Reset pulsed mid-read: no DONE, then a clean restart.
    @(negedge clk);
    drive(1'b0, 32'h0000_8020, 1'b1, 1'b0, 32'h0);
    @(posedge clk);
    #1 drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    rstx3 = 1'b0;
    ndone = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus3.MEMDONE) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    check("abort_busy", 32'(bus3.MEMBUSY), 32'd0);
    check("abort_rdcnt", 32'(rdcnt3), 32'd0);
    rstx3 = 1'b1;
    access(1'b0, 32'h0000_8020, 1'b1, 1'b0, 32'h0, 32'd2, q);
    check("restart_rdcnt", 32'(rdcnt3), 32'd1);

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
